// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: classifies each committed instruction, stamps a sequence
// number and queues the record for a trace sink; records that find the FIFO full are dropped and counted.
module commit_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int SEQ_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             commit_valid_i,
  input  logic [PC_W-1:0]  commit_pc_i,
  input  logic [31:0]      commit_instr_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [PC_W-1:0]  trace_pc_o,
  output logic [31:0]      trace_instr_o,
  output logic [2:0]       trace_class_o,
  output logic             trace_rvc_o,
  output logic [SEQ_W-1:0] trace_seq_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] load_cnt_o,
  output logic [CNT_W-1:0] store_cnt_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] jump_cnt_o
);
  // Handshake: a record leaves the FIFO on a cycle where trace_valid_o && trace_ready_i;
  // the head stays stable while valid && !ready.
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = PC_W + 32 + 3 + 1 + SEQ_W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] CLS_OTHER  = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;
  localparam logic [2:0] CLS_CSR    = 3'd5;
  localparam logic [2:0] CLS_SYSTEM = 3'd6;
  localparam logic [2:0] CLS_AMO    = 3'd7;

  function automatic logic [2:0] classify(input logic [31:0] ins);
    logic [2:0] c;
    c = CLS_OTHER;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'b0000011, 7'b0000111: c = CLS_LOAD;
        7'b0100011, 7'b0100111: c = CLS_STORE;
        7'b1100011:             c = CLS_BRANCH;
        7'b1101111:             c = CLS_JUMP;
        7'b1100111:             c = (ins[14:12] == 3'b000) ? CLS_JUMP : CLS_OTHER;
        7'b1110011:             c = (ins[14:12] == 3'b000) ? CLS_SYSTEM : CLS_CSR;
        7'b0101111:             c = CLS_AMO;
        default:                c = CLS_OTHER;
      endcase
    end else begin
      // Compressed: quadrant in [1:0], funct3 in [15:13]
      case ({ins[1:0], ins[15:13]})
        5'b00_001, 5'b00_010, 5'b00_011: c = CLS_LOAD;
        5'b00_101, 5'b00_110, 5'b00_111: c = CLS_STORE;
        5'b01_001, 5'b01_101:            c = CLS_JUMP;
        5'b01_110, 5'b01_111:            c = CLS_BRANCH;
        5'b10_001, 5'b10_010, 5'b10_011: c = CLS_LOAD;
        5'b10_101, 5'b10_110, 5'b10_111: c = CLS_STORE;
        5'b10_100: begin
          if (ins[15:0] == 16'h9002)
            c = CLS_SYSTEM;
          else if ((ins[11:7] != 5'd0) && (ins[6:2] == 5'd0))
            c = CLS_JUMP;
          else
            c = CLS_OTHER;
        end
        default: c = CLS_OTHER;
      endcase
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              flush;
  logic [2:0]        cls_in;
  logic              s1_valid_q;
  logic [REC_W-1:0]  s1_rec_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              push, pop, drop;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  load_q, load_d, store_q, store_d;
  logic [CNT_W-1:0]  branch_q, branch_d, jump_q, jump_d;
  logic [REC_W-1:0]  head_rec;

  assign flush  = rst_i || clear_i;
  assign cls_in = classify(commit_instr_i);

  always_ff @(posedge clk_i) begin
    if (flush) begin
      s1_valid_q <= 1'b0;
      s1_rec_q   <= '0;
      seq_q      <= '0;
    end else begin
      s1_valid_q <= commit_valid_i;
      if (commit_valid_i) begin
        s1_rec_q <= {commit_pc_i, commit_instr_i, cls_in,
                     (commit_instr_i[1:0] != 2'b11), seq_q};
        seq_q    <= seq_q + 1'b1;
      end
    end
  end

  assign trace_valid_o = (count_q != '0);
  assign pop  = trace_valid_o && trace_ready_i;
  assign push = s1_valid_q && ((count_q != FULL_CNT) || pop);
  assign drop = s1_valid_q && (count_q == FULL_CNT) && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    load_d     = load_q;
    store_d    = store_q;
    branch_d   = branch_q;
    jump_d     = jump_q;
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
    // Class statistics count commits, so dropped records are still included
    if (commit_valid_i) begin
      case (cls_in)
        CLS_LOAD:   load_d   = sat_inc(load_q);
        CLS_STORE:  store_d  = sat_inc(store_q);
        CLS_BRANCH: branch_d = sat_inc(branch_q);
        CLS_JUMP:   jump_d   = sat_inc(jump_q);
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      load_q     <= '0;
      store_q    <= '0;
      branch_q   <= '0;
      jump_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      load_q     <= load_d;
      store_q    <= store_d;
      branch_q   <= branch_d;
      jump_q     <= jump_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush)
      mem_q[wr_ptr_q] <= s1_rec_q;
  end

  assign head_rec = trace_valid_o ? mem_q[rd_ptr_q] : '0;
  assign {trace_pc_o, trace_instr_o, trace_class_o, trace_rvc_o, trace_seq_o} = head_rec;

  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign load_cnt_o   = load_q;
  assign store_cnt_o  = store_q;
  assign branch_cnt_o = branch_q;
  assign jump_cnt_o   = jump_q;

endmodule
